// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// MemConsts: shared definitions for the data memory responder.
//   - MemRespState : responder FSM state encoding
//   - WAIT_W       : width of the wait-state counter
//   - in_range()   : byte-address window check for [base, base + depth*4)
// -----------------------------------------------------------------------------
package MemConsts;

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    R_WAIT = 3'd1,
    W_WAIT = 3'd2,
    R_RESP = 3'd3,
    W_RESP = 3'd4
  } MemRespState;

  // 34-bit compare so a window ending exactly at 2^32 does not wrap.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth);
    logic [33:0] span;
    logic [33:0] off;
    span = {depth, 2'b00};
    off  = {2'b00, addr - base};
    return (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// Load/store bus interfaces between the core's load/store unit (Master) and
// the data memory responder (Slave).
//   ReadIF : req, addr (master -> slave); ready, data (slave -> master)
//   WriteIF: req, addr, data, strb (master -> slave); ready (slave -> master)
// -----------------------------------------------------------------------------
interface ReadIF;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] data;

  modport Master (output req, output addr, input  ready, input  data);
  modport Slave  (input  req, input  addr, output ready, output data);
endinterface

interface WriteIF;
  logic        req;
  logic [31:0] addr;
  logic [31:0] data;
  logic [3:0]  strb;
  logic        ready;

  modport Master (output req, output addr, output data, output strb, input  ready);
  modport Slave  (input  req, input  addr, input  data, input  strb, output ready);
endinterface

// File: rtl/data_mem_responder_byte_en_ram.sv
// -----------------------------------------------------------------------------
// byte_en_ram: single-port DEPTH_WORDS x 32 RAM, synchronous read, per-byte
// write enable, no reset.
//   clk     : clock, rising edge
//   addr_i  : word index
//   we_i    : per-lane write enable (lane i = bits [8i+7:8i])
//   wdata_i : write word
//   rdata_o : word at the address presented in the previous cycle
//             (old data on a read-during-write)
// -----------------------------------------------------------------------------
module byte_en_ram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-lane writes and registered read port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder: slave-side data memory for the core load/store bus.
// One FSM serialises reads and writes (write wins on a tie), inserts
// READ_WAIT / WRITE_WAIT wait states and returns single-cycle ready pulses.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   r_bus  : ReadIF.Slave  - read request in, ready/data out
//   w_bus  : WriteIF.Slave - write request in, ready out
//   fault  : sticky flag, set by any access outside the memory window
// -----------------------------------------------------------------------------
module data_mem_responder
  import MemConsts::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned READ_WAIT   = 1,
  parameter int unsigned WRITE_WAIT  = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  ReadIF.Slave   r_bus,
  WriteIF.Slave  w_bus,
  output logic   fault
);

  localparam int unsigned       AW    = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_W-1:0] RD_WT = WAIT_W'(READ_WAIT);
  localparam logic [WAIT_W-1:0] WR_WT = WAIT_W'(WRITE_WAIT);

  MemRespState       state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        strb_q, strb_d;
  logic              oor_q, oor_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic              r_ready_q, w_ready_q;

  logic [AW-1:0]     ram_addr_s;
  logic [3:0]        ram_we_s;
  logic [31:0]       ram_rdata_s;
  logic [31:0]       resp_word_s;

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 32'd2);
  endfunction

  // In IDLE the RAM is addressed straight from the read bus so that a
  // zero-wait read already has its word in the following (R_RESP) cycle.
  assign ram_addr_s  = (state_q == IDLE) ? word_idx(r_bus.addr) : word_idx(addr_q);
  assign ram_we_s    = ((state_q == W_RESP) && !oor_q) ? strb_q : 4'b0000;
  assign resp_word_s = oor_q ? 32'h0000_0000 : ram_rdata_s;

  byte_en_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .addr_i  (ram_addr_s),
    .we_i    (ram_we_s),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata_s)
  );

  // Next-state, acceptance latches, wait counter and sticky fault.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    oor_d   = oor_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (w_bus.req) begin
          addr_d  = w_bus.addr;
          wdata_d = w_bus.data;
          strb_d  = w_bus.strb;
          oor_d   = !in_range(w_bus.addr, BASE_ADDR, 32'(DEPTH_WORDS));
          fault_d = fault_q | oor_d;
          cnt_d   = WR_WT;
          state_d = (WR_WT == 4'd0) ? W_RESP : W_WAIT;
        end else if (r_bus.req) begin
          addr_d  = r_bus.addr;
          oor_d   = !in_range(r_bus.addr, BASE_ADDR, 32'(DEPTH_WORDS));
          fault_d = fault_q | oor_d;
          cnt_d   = RD_WT;
          state_d = (RD_WT == 4'd0) ? R_RESP : R_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      R_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = R_RESP;
        end else begin
          state_d = R_WAIT;
        end
      end
      W_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = W_RESP;
        end else begin
          state_d = W_WAIT;
        end
      end
      R_RESP: begin
        // Capture the returned word so it holds until the next read.
        rdata_d = resp_word_s;
        state_d = IDLE;
      end
      W_RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; ready pulses follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      strb_q    <= 4'b0000;
      oor_q     <= 1'b0;
      rdata_q   <= 32'h0000_0000;
      fault_q   <= 1'b0;
      r_ready_q <= 1'b0;
      w_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      oor_q     <= oor_d;
      rdata_q   <= rdata_d;
      fault_q   <= fault_d;
      r_ready_q <= (state_d == R_RESP);
      w_ready_q <= (state_d == W_RESP);
    end
  end

  // During R_RESP the freshly read word is presented; otherwise the held one.
  assign r_bus.data  = (state_q == R_RESP) ? resp_word_s : rdata_q;
  assign r_bus.ready = r_ready_q;
  assign w_bus.ready = w_ready_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// Directed bench for data_mem_responder. Three instances:
//   0: DEPTH 4096, READ_WAIT 1,  WRITE_WAIT 0 (basic, strobes, tie)
//   1: DEPTH 16,   READ_WAIT 0,  WRITE_WAIT 0 (out-of-range, zero wait)
//   2: DEPTH 4096, READ_WAIT 15, WRITE_WAIT 3 (reset mid-write, long wait)
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic clk;
  logic rst_n;
  logic rst_c;

  logic        rreq  [3];
  logic [31:0] raddr [3];
  logic        wreq  [3];
  logic [31:0] waddr [3];
  logic [31:0] wdat  [3];
  logic [3:0]  wstrb [3];
  logic        rrdy  [3];
  logic [31:0] rdat  [3];
  logic        wrdy  [3];
  logic        flt   [3];

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;

  ReadIF  r0 (); ReadIF  r1 (); ReadIF  r2 ();
  WriteIF w0 (); WriteIF w1 (); WriteIF w2 ();

  assign r0.req = rreq[0]; assign r0.addr = raddr[0];
  assign r1.req = rreq[1]; assign r1.addr = raddr[1];
  assign r2.req = rreq[2]; assign r2.addr = raddr[2];
  assign w0.req = wreq[0]; assign w0.addr = waddr[0]; assign w0.data = wdat[0]; assign w0.strb = wstrb[0];
  assign w1.req = wreq[1]; assign w1.addr = waddr[1]; assign w1.data = wdat[1]; assign w1.strb = wstrb[1];
  assign w2.req = wreq[2]; assign w2.addr = waddr[2]; assign w2.data = wdat[2]; assign w2.strb = wstrb[2];
  assign rrdy[0] = r0.ready; assign rdat[0] = r0.data; assign wrdy[0] = w0.ready;
  assign rrdy[1] = r1.ready; assign rdat[1] = r1.data; assign wrdy[1] = w1.ready;
  assign rrdy[2] = r2.ready; assign rdat[2] = r2.data; assign wrdy[2] = w2.ready;

  data_mem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .READ_WAIT(1), .WRITE_WAIT(0))
    u0 (.clk(clk), .rst_n(rst_n), .r_bus(r0), .w_bus(w0), .fault(flt[0]));
  data_mem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .READ_WAIT(0), .WRITE_WAIT(0))
    u1 (.clk(clk), .rst_n(rst_n), .r_bus(r1), .w_bus(w1), .fault(flt[1]));
  data_mem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .READ_WAIT(15), .WRITE_WAIT(3))
    u2 (.clk(clk), .rst_n(rst_c), .r_bus(r2), .w_bus(w2), .fault(flt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Both ready lines of one instance must never be high together.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rrdy[k] === 1'b1 && wrdy[k] === 1'b1) overlap++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int exp_lat, input string tag);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    wreq[k] = 1'b1; waddr[k] = a; wdat[k] = d; wstrb[k] = s;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (wrdy[k] === 1'b1) begin
        lat = n;
        break;
      end
    end
    wreq[k] = 1'b0;
    chk({tag, "_wlat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic do_read(input int k, input logic [31:0] a, input int exp_lat,
                         input logic [31:0] exp_d, input string tag);
    int          lat;
    logic [31:0] d;
    lat = 0;
    d   = 32'h0;
    @(posedge clk); #1;
    rreq[k] = 1'b1; raddr[k] = a;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (rrdy[k] === 1'b1) begin
        lat = n;
        d   = rdat[k];
        break;
      end
    end
    rreq[k] = 1'b0;
    chk({tag, "_rlat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, d, exp_d);
  endtask

  initial begin
    int wcyc, rcyc, pulses;
    logic [31:0] rd;
    for (int k = 0; k < 3; k++) begin
      rreq[k] = 1'b0; raddr[k] = 32'h0; wreq[k] = 1'b0;
      waddr[k] = 32'h0; wdat[k] = 32'h0; wstrb[k] = 4'h0;
    end
    rst_n = 1'b0; rst_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; rst_c = 1'b1;

    // Reset state
    chk("rst_rrdy",  32'(rrdy[0]), 32'd0);
    chk("rst_wrdy",  32'(wrdy[0]), 32'd0);
    chk("rst_rdata", rdat[0], 32'h0);
    chk("rst_fault", 32'(flt[0]), 32'd0);

    // Basic write/read and byte strobes (read directly after W_RESP)
    do_write(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, "basic");
    do_read (0, 32'h10, 2, 32'hDEAD_BEEF, "basic");
    do_write(0, 32'h10, 32'h0000_00AA, 4'b0001, 1, "strb");
    do_read (0, 32'h10, 2, 32'hDEAD_BEAA, "strb");
    @(posedge clk); #1;
    chk("rdata_hold", rdat[0], 32'hDEAD_BEAA);

    // Simultaneous write and read: write first, read served afterwards
    wcyc = 0; rcyc = 0; rd = 32'h0;
    @(posedge clk); #1;
    wreq[0] = 1'b1; waddr[0] = 32'h20; wdat[0] = 32'h1234_5678; wstrb[0] = 4'hF;
    rreq[0] = 1'b1; raddr[0] = 32'h20;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (wrdy[0] === 1'b1) begin wcyc = n; wreq[0] = 1'b0; end
      if (rrdy[0] === 1'b1) begin rcyc = n; rd = rdat[0]; rreq[0] = 1'b0; end
      if (rcyc != 0) break;
    end
    wreq[0] = 1'b0; rreq[0] = 1'b0;
    chk("tie_wcyc",  32'(wcyc), 32'd1);
    chk("tie_rcyc",  32'(rcyc), 32'd4);
    chk("tie_rdata", rd, 32'h1234_5678);

    // Out-of-range on a 16-word memory, zero read wait
    do_write(1, 32'h00, 32'hCAFE_F00D, 4'hF, 1, "oor_w0");
    do_read (1, 32'h00, 1, 32'hCAFE_F00D, "rw0");
    do_write(1, 32'h3C, 32'h0BAD_C0DE, 4'hF, 1, "top_w");
    do_read (1, 32'h3C, 1, 32'h0BAD_C0DE, "top_r");
    chk("fault_clear", 32'(flt[1]), 32'd0);
    do_write(1, 32'h40, 32'hFFFF_FFFF, 4'hF, 1, "oor_w");
    chk("fault_set", 32'(flt[1]), 32'd1);
    do_read (1, 32'h00, 1, 32'hCAFE_F00D, "word0_kept");
    do_read (1, 32'h40, 1, 32'h0, "oor_r");
    chk("fault_sticky", 32'(flt[1]), 32'd1);

    // Long waits, then reset in write wait cycle 2
    do_write(2, 32'h08, 32'h1111_1111, 4'hF, 4, "w3");
    do_read (2, 32'h4000, 16, 32'h0, "oor_r15");
    chk("fault2_set", 32'(flt[2]), 32'd1);
    do_read (2, 32'h08, 16, 32'h1111_1111, "r15");
    @(posedge clk); #1;
    wreq[2] = 1'b1; waddr[2] = 32'h08; wdat[2] = 32'h0000_0055; wstrb[2] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_c = 1'b0; wreq[2] = 1'b0;
    #1;
    chk("mid_rst_wrdy",  32'(wrdy[2]), 32'd0);
    chk("mid_rst_rrdy",  32'(rrdy[2]), 32'd0);
    chk("mid_rst_rdata", rdat[2], 32'h0);
    chk("mid_rst_fault", 32'(flt[2]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_c = 1'b1;
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (wrdy[2] === 1'b1 || rrdy[2] === 1'b1) pulses++;
    end
    chk("post_rst_pulses", 32'(pulses), 32'd0);
    do_read (2, 32'h08, 16, 32'h1111_1111, "aborted_w");

    chk("ready_overlap", 32'(overlap), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Slave-side data memory that answers the core's load/store bus: it is the responder on the `ReadIF`/`WriteIF` pair that the execute stage's load/store unit drives as master. It holds a word-organised RAM with byte strobes. It inserts a configurable number of wait states, serialises reads and writes through one FSM and returns one-cycle `ready` pulses. It is instantiated at SoC level between the core's data port and the backing memory, and also serves as the bus model in core benches.

## Interface

Parameters:
- `DEPTH_WORDS`, 4096: RAM size in 32-bit words; power of two, at least 2.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `READ_WAIT`, 1: wait cycles inserted before a read response (0..15).
- `WRITE_WAIT`, 0: wait cycles inserted before a write response (0..15).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `r_bus`  ReadIF.Slave  master drives `req`(1) and `addr`(32); slave drives `ready`(1) and `data`(32).
- `w_bus`  WriteIF.Slave  master drives `req`(1), `addr`(32), `data`(32) and `strb`(4); slave drives `ready`(1).
- `fault`  out  1  sticky flag: an access outside `[BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4)` has occurred.

## Operation

- FSM states: `IDLE`, `R_WAIT`, `W_WAIT`, `R_RESP`, `W_RESP`.
- **IDLE:**
  - `w_bus.req` goes to `W_WAIT`. If `WRITE_WAIT`=0 it goes straight to `W_RESP`.
  - Otherwise `r_bus.req` goes to `R_WAIT`. If `READ_WAIT`=0 it goes straight to `R_RESP`.
  - Write has priority when both requests are high; the read stays pending and is served afterwards.
- **Acceptance:** on acceptance the block latches `addr`, plus `data` and `strb` for a write, and loads the 4-bit wait counter.
- **R_WAIT/W_WAIT:** the counter decrements each cycle. On the cycle it reaches 1, the FSM moves to the matching `RESP` state. Request inputs are ignored in these states.
- **R_RESP:** `r_bus.ready`=1 for exactly one cycle. `r_bus.data` holds the word at the latched address. Next state is `IDLE`.
- **W_RESP:** `w_bus.ready`=1 for exactly one cycle. RAM lanes with `strb[i]`=1 are updated at the closing edge of this cycle. Next state is `IDLE`.
- **Word index:** `(addr - BASE_ADDR) >> 2`. `addr[1:0]` is ignored; lane alignment and strobes belong to the master. Reads always return the full word.
- **Out-of-range access:**
  - A read still responds, with `data`=0.
  - A write still responds, but no RAM update is made.
  - `fault` is set and stays set until reset.
- `r_bus.data` updates only when entering `R_RESP` and holds between reads.
- **Master rule:** `req` is held until `ready` is seen and dropped in the following cycle. If `req` is still high in the `IDLE` cycle after a response, that is a new transaction.

## Timing

- **Read latency:** acceptance at cycle 0; `r_bus.ready` high in cycle `READ_WAIT+1`.
- **Write latency:** acceptance at cycle 0; `w_bus.ready` high in cycle `WRITE_WAIT+1`. The RAM is updated at the end of that cycle.
- Back-to-back accesses cost one `IDLE` cycle between transactions. Minimum period is `WAIT+2` cycles.
- A read accepted in the cycle after `W_RESP` returns the newly written data.
- **Reset values:** state `IDLE`, both `ready`=0, `r_bus.data`=0, `fault`=0, wait counter 0. RAM contents are not reset.
- **Reset mid-transaction:** the transaction is aborted. A pending write is not committed. No `ready` is issued for it after reset deasserts.
- `ready` is never high on both buses in the same cycle.

## Structure

- **Shared package (`MemConsts`):**
  - FSM state enum `MemRespState`.
  - Wait-counter width constant (4).
  - Address-range check function `in_range(addr, base, depth)`.
- **Sub-module `byte_en_ram`:** single-port, `DEPTH_WORDS`x32, synchronous read, per-byte write enable, no reset. The FSM, latches, counter and range check live in `data_mem_responder`.

## Test plan

- **Basic write and read:** `READ_WAIT`=1, `WRITE_WAIT`=0. Write 0xDEADBEEF to 0x10 with strb 4'hF, then read 0x10.
  - `w_bus.ready` in cycle 1.
  - `r_bus.ready` 2 cycles after read acceptance, with data 0xDEADBEEF.
- **Byte strobes:** after the write above, write 0x000000AA to 0x10 with strb 4'b0001, then read 0x10 → 0xDEADBEAA.
- **Simultaneous requests:** write (0x20, 0x12345678) and read (0x20) asserted in the same `IDLE` cycle.
  - Write served first.
  - Read served next and returns 0x12345678.
  - The two `ready` pulses are never concurrent.
- **Out-of-range access:** `DEPTH_WORDS`=16, `BASE_ADDR`=0.
  - Write to 0x40 → `ready` pulses, `fault`=1, word 0 unchanged.
  - Read from 0x40 → data 0.
- **Reset during write wait:** `WRITE_WAIT`=3, write 0x55 to 0x8; pull `rst_n` low in wait cycle 2.
  - Outputs go to reset values at once; `fault`=0.
  - A later read of 0x8 returns the old contents.
- **Wait-state sweep:** `READ_WAIT` in {0, 15} → `ready` observed exactly 1 and 16 cycles after acceptance.
